// File: rtl/rr_arbiter_4.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rr_arbiter_4                                                    |
// | Purpose  : Round-robin arbiter granting one shared resource to one of four |
// |            requesters per cycle. Winner is held while it keeps requesting; |
// |            on release the search restarts just after the old owner.        |
// | Ports    : i_clk        clock, rising edge                                 |
// |            i_reset      synchronous reset, active-high                     |
// |            i_req[3:0]   request vector, bit n = requester n                |
// |            o_grant[3:0] registered one-hot grant, 0 when idle              |
// |            o_grant_idx  binary owner index, meaningful when o_valid=1      |
// |            o_valid      a requester currently owns the grant               |
// |            o_timeout    1-cycle pulse on forced release                    |
// | Options  : ARB_TIMEOUT_EN - when defined, an owner holding for HOLD_MAX    |
// |            cycles while others wait is forced to hand over. When not       |
// |            defined there is no hold counter and o_timeout is tied low.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module rr_arbiter_4 #(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [3:0] i_req,
  output logic [3:0] o_grant,
  output logic [1:0] o_grant_idx,
  output logic       o_valid,
  output logic       o_timeout
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] grant_q, grant_d;

  // Position right after the current owner; both the new pointer and the
  // search start whenever the owner lets go.
  logic [1:0] w_after_owner;
  assign w_after_owner = idx_q + 2'd1;

  // Requests from everyone except the current owner.
  logic [3:0] w_others;
  assign w_others = i_req & ~grant_q;

  // Sizing sanity: an illegal HOLD_MAX/CNT_W pair elaborates this named,
  // empty scope so it is easy to spot in the hierarchy.
  if ((HOLD_MAX < 2) || ((1 << CNT_W) <= HOLD_MAX)) begin : g_bad_hold_cfg
  end

  // First set bit of req, scanning start, start+1, start+2, start+3 with
  // 2-bit wrap. The descending loop lets the smallest offset overwrite last.
  // Only called with a non-zero req.
  function automatic logic [1:0] rr_pick(input logic [3:0] req,
                                         input logic [1:0] start);
    logic [1:0] res;
    logic [1:0] cand;
    res = start;
    for (int k = 3; k >= 0; k--) begin
      cand = start + 2'(k);
      if (req[cand]) res = cand;
    end
    return res;
  endfunction

`ifdef ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        // Pointer is deliberately left alone on a grant out of idle.
        if (|i_req) begin
          state_d = ST_GRANT;
          idx_d   = rr_pick(i_req, ptr_q);
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end

      ST_GRANT: begin
        if (i_req[idx_q]) begin
`ifdef ARB_TIMEOUT_EN
          if (cnt_q == C_HOLD_LAST) begin
            // Hold budget used up: rotate only if somebody else is waiting,
            // otherwise the owner simply starts a fresh budget.
            cnt_d = '0;
            if (|w_others) begin
              ptr_d     = w_after_owner;
              idx_d     = rr_pick(w_others, w_after_owner);
              timeout_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end else begin
          // Owner released: hand straight over if anyone else asks, no
          // idle bubble in between.
          ptr_d = w_after_owner;
          if (|i_req) begin
            idx_d = rr_pick(i_req, w_after_owner);
`ifdef ARB_TIMEOUT_EN
            cnt_d = '0;
`endif
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    grant_d = (state_d == ST_GRANT) ? (4'b0001 << idx_d) : 4'b0000;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= 2'b00;
      idx_q   <= 2'b00;
      grant_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      grant_q <= grant_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

  assign o_grant     = grant_q;
  assign o_grant_idx = idx_q;
  assign o_valid     = (state_q == ST_GRANT);

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_4.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_rr_arbiter_4                                                 |
// | Purpose  : Self-checking bench for rr_arbiter_4. A behavioural model      |
// |            predicts each cycle's outputs into a scoreboard queue, which    |
// |            is popped and compared after the clock edge; directed checks    |
// |            cover the reset, single, rotation, handover, hold/timeout and   |
// |            mid-grant reset scenarios, followed by random traffic.          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_rr_arbiter_4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] o_grant;
  logic [1:0] o_grant_idx;
  logic       o_valid;
  logic       o_timeout;

  always #5 clk = ~clk;

  rr_arbiter_4 #(
    .HOLD_MAX (8),
    .CNT_W    (4)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_req       (req),
    .o_grant     (o_grant),
    .o_grant_idx (o_grant_idx),
    .o_valid     (o_valid),
    .o_timeout   (o_timeout)
  );

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] idx;
    logic       valid;
    logic       tmo;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state
  logic       m_valid = 1'b0;
  logic [1:0] m_owner = 2'b00;
  logic [1:0] m_ptr   = 2'b00;
  int         m_cnt   = 0;
  logic       m_to    = 1'b0;

  task automatic check(input string tag, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Round-robin search written as an offset scan from p.
  function automatic logic [1:0] first_from(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] res;
    logic       found;
    int         pos;
    res   = 2'b00;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      pos = (int'(p) + k) % 4;
      if (!found && r[pos]) begin
        res   = 2'(pos);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  task automatic model_step(input logic [3:0] r, input logic rs);
    logic [3:0] others;
    m_to = 1'b0;
    if (rs) begin
      m_valid = 1'b0;
      m_owner = 2'b00;
      m_ptr   = 2'b00;
      m_cnt   = 0;
    end else if (!m_valid) begin
      if (r != 4'b0000) begin
        m_valid = 1'b1;
        m_owner = first_from(r, m_ptr);
        m_cnt   = 0;
      end
    end else if (r[m_owner]) begin
      others = r & ~(4'b0001 << m_owner);
`ifdef ARB_TIMEOUT_EN
      if (m_cnt == 8 - 1) begin
        m_cnt = 0;
        if (others != 4'b0000) begin
          m_ptr   = m_owner + 2'd1;
          m_owner = first_from(others, m_ptr);
          m_to    = 1'b1;
        end
      end else begin
        m_cnt++;
      end
`else
      if (others != 4'b0000) m_cnt = 0;
`endif
    end else begin
      m_ptr = m_owner + 2'd1;
      if (r != 4'b0000) begin
        m_owner = first_from(r, m_ptr);
        m_cnt   = 0;
      end else begin
        m_valid = 1'b0;
      end
    end
  endtask

  // Drive one cycle of stimulus, predict, then compare after the edge.
  task automatic cycle(input logic [3:0] r, input logic rs);
    exp_t e;
    @(negedge clk);
    req = r;
    rst = rs;
    model_step(r, rs);
    e.grant = m_valid ? (4'b0001 << m_owner) : 4'b0000;
    e.idx   = m_owner;
    e.valid = m_valid;
    e.tmo   = m_to;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 4'b0000, 4'b0001);
    end else begin
      e = sb_q.pop_front();
      check("grant", o_grant, e.grant);
      check("valid", {3'b000, o_valid}, {3'b000, e.valid});
      if (e.valid) check("idx", {2'b00, o_grant_idx}, {2'b00, e.idx});
      check("timeout", {3'b000, o_timeout}, {3'b000, e.tmo});
    end
  endtask

  initial begin
    // Reset held two cycles with all requesting
    cycle(4'b1111, 1'b1);
    cycle(4'b1111, 1'b1);
    check("rst_grant", o_grant, 4'b0000);
    check("rst_valid", {3'b000, o_valid}, 4'b0000);
    check("rst_idx", {2'b00, o_grant_idx}, 4'b0000);
    check("rst_tmo", {3'b000, o_timeout}, 4'b0000);
    cycle(4'b1111, 1'b0);
    check("rel_grant", o_grant, 4'b0001);
    check("rel_idx", {2'b00, o_grant_idx}, 4'b0000);

    // Single requester
    cycle(4'b0000, 1'b1);
    cycle(4'b0100, 1'b0);
    check("single_grant", o_grant, 4'b0100);
    check("single_idx", {2'b00, o_grant_idx}, 4'b0010);
    cycle(4'b0000, 1'b0);
    check("single_drop", o_grant, 4'b0000);
    check("single_valid", {3'b000, o_valid}, 4'b0000);

    // Rotation with 3->0 wrap
    cycle(4'b0000, 1'b1);
    cycle(4'b1111, 1'b0);
    check("rot0", o_grant, 4'b0001);
    cycle(4'b1110, 1'b0);
    check("rot1", o_grant, 4'b0010);
    cycle(4'b1111, 1'b0);
    cycle(4'b1101, 1'b0);
    check("rot2", o_grant, 4'b0100);
    cycle(4'b1111, 1'b0);
    cycle(4'b1011, 1'b0);
    check("rot3", o_grant, 4'b1000);
    cycle(4'b1111, 1'b0);
    cycle(4'b0111, 1'b0);
    check("rot_wrap", o_grant, 4'b0001);

    // Handover without a bubble
    cycle(4'b0000, 1'b1);
    cycle(4'b0010, 1'b0);
    check("ho_owner1", o_grant, 4'b0010);
    cycle(4'b1011, 1'b0);
    check("ho_hold", o_grant, 4'b0010);
    cycle(4'b1001, 1'b0);
    check("ho_next", o_grant, 4'b1000);
    check("ho_valid", {3'b000, o_valid}, 4'b0001);

    // Long hold with a competitor waiting
    cycle(4'b0000, 1'b1);
    for (int i = 0; i < 8; i++) cycle(4'b0011, 1'b0);
    check("hold8_grant", o_grant, 4'b0001);
    check("hold8_tmo", {3'b000, o_timeout}, 4'b0000);
    cycle(4'b0011, 1'b0);
`ifdef ARB_TIMEOUT_EN
    check("to_grant", o_grant, 4'b0010);
    check("to_pulse", {3'b000, o_timeout}, 4'b0001);
`else
    check("nto_grant", o_grant, 4'b0001);
    check("nto_pulse", {3'b000, o_timeout}, 4'b0000);
`endif
    for (int i = 0; i < 20; i++) cycle(4'b0011, 1'b0);
    // Sole requester never times out
    for (int i = 0; i < 20; i++) cycle(4'b0001, 1'b0);
    check("solo_grant", o_grant, 4'b0001);
    check("solo_tmo", {3'b000, o_timeout}, 4'b0000);

    // Reset in the middle of a grant
    cycle(4'b0000, 1'b1);
    cycle(4'b0100, 1'b0);
    cycle(4'b0100, 1'b0);
    check("mid_owner2", o_grant, 4'b0100);
    cycle(4'b0100, 1'b1);
    check("mid_rst_grant", o_grant, 4'b0000);
    check("mid_rst_valid", {3'b000, o_valid}, 4'b0000);
    cycle(4'b0110, 1'b0);
    check("mid_after", o_grant, 4'b0010);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 39) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
